// File: rtl/ap_perf_pkg.sv
// ap_ctrl performance monitor shared types.
// Widest supported timestamp; instances slice to their widths.
package ap_perf_pkg;
  localparam int PKG_W = 64;

  typedef logic [PKG_W-1:0] ts_t;
  typedef logic [PKG_W-1:0] cnt_t;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FULL
  } ch_state_e;

  function automatic ts_t lat_diff(ts_t now, ts_t then);
    return now - then;
  endfunction
endpackage

// File: rtl/ap_perf_channel.sv
// One channel: timestamp FIFO, occupancy FSM and statistics.
// Overlapping transactions are matched in start order.
module ap_perf_channel
  import ap_perf_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int TS_W         = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             finish,
  input  logic             start,
  input  logic             ready,
  input  logic             done,
  input  logic             cont,
  input  logic [TS_W-1:0]  now,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] min_lat,
  output logic [CNT_W-1:0] max_lat,
  output logic [CNT_W-1:0] stall,
  output logic [1:0]       err,
  output logic             idle
);
  localparam int AW =
    (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int OW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [OW-1:0] DEPTH = OW'(MAX_INFLIGHT);

  ch_state_e       state, state_nxt;
  logic [TS_W-1:0] mem [MAX_INFLIGHT];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [OW-1:0]   occ, occ_nxt;
  logic [CNT_W-1:0] lat, head_lat;
  logic en, push, pop, both, ponly, oonly;
  logic wr, rd, ovf, udf, upd, stl;
  logic empty, full;

  function automatic logic [AW-1:0] nxt(
    logic [AW-1:0] p
  );
    return (MAX_INFLIGHT == 1) ? '0 : p + 1'b1;
  endfunction

  assign empty = (state == IDLE);
  assign full  = (state == FULL);
  assign idle  = empty;
  assign head_lat = CNT_W'(lat_diff(ts_t'(now),
                                    ts_t'(mem[rd_ptr])));

  // Classify this cycle's accepted handshakes.
  always_comb begin
    en    = !clear && !finish;
    push  = en && start && ready;
    pop   = en && done && cont;
    stl   = en && done && !cont;
    both  = push && pop;
    ponly = push && !pop;
    oonly = pop && !push;
    wr    = 1'b0;
    rd    = 1'b0;
    ovf   = 1'b0;
    udf   = 1'b0;
    upd   = 1'b0;
    lat   = '0;
    unique case (1'b1)
      both && empty:   upd = 1'b1;
      both && !empty: begin
        wr  = 1'b1;
        rd  = 1'b1;
        upd = 1'b1;
        lat = head_lat;
      end
      ponly && full:   ovf = 1'b1;
      ponly && !full:  wr  = 1'b1;
      oonly && empty:  udf = 1'b1;
      oonly && !empty: begin
        rd  = 1'b1;
        upd = 1'b1;
        lat = head_lat;
      end
      default: ;
    endcase
  end

  // Occupancy bookkeeping and FSM next state.
  always_comb begin
    occ_nxt   = occ;
    state_nxt = state;
    if (wr && !rd) occ_nxt = occ + 1'b1;
    if (rd && !wr) occ_nxt = occ - 1'b1;
    unique case (state)
      IDLE:
        if (wr)
          state_nxt = (occ_nxt == DEPTH) ? FULL : BUSY;
      BUSY:
        if (occ_nxt == '0)
          state_nxt = IDLE;
        else if (occ_nxt == DEPTH)
          state_nxt = FULL;
      FULL:
        if (rd && !wr)
          state_nxt = (occ_nxt == '0) ? IDLE : BUSY;
      default: state_nxt = IDLE;
    endcase
  end

  // Timestamp storage; contents are only valid below occ.
  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr] <= now;
  end

  // FSM, pointers and statistics registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      txn_count <= '0;
      last_lat  <= '0;
      min_lat   <= '1;
      max_lat   <= '0;
      stall     <= '0;
      err       <= '0;
    end else if (clear) begin
      state     <= IDLE;
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      txn_count <= '0;
      last_lat  <= '0;
      min_lat   <= '1;
      max_lat   <= '0;
      stall     <= '0;
      err       <= '0;
    end else begin
      state <= state_nxt;
      occ   <= occ_nxt;
      if (wr) wr_ptr <= nxt(wr_ptr);
      if (rd) rd_ptr <= nxt(rd_ptr);
      if (push && txn_count != '1)
        txn_count <= txn_count + 1'b1;
      if (stl && stall != '1)
        stall <= stall + 1'b1;
      if (upd) begin
        last_lat <= lat;
        if (lat < min_lat) min_lat <= lat;
        if (lat > max_lat) max_lat <= lat;
      end
      if (ovf) err[ERR_OVF] <= 1'b1;
      if (udf) err[ERR_UDF] <= 1'b1;
    end
  end
endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl handshake performance monitor.
// Shared timestamp counter plus registered statistics readout.
module ap_ctrl_perf_monitor
  import ap_perf_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int TS_W         = 32,
  parameter int MAX_INFLIGHT = 4,
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [SW-1:0]     rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_txn_count,
  output logic [CNT_W-1:0]  rd_last_lat,
  output logic [CNT_W-1:0]  rd_min_lat,
  output logic [CNT_W-1:0]  rd_max_lat,
  output logic [CNT_W-1:0]  rd_stall,
  output logic [1:0]        rd_err,
  output logic [TS_W-1:0]   cycle_count,
  output logic              all_idle
);
  logic [CNT_W-1:0] txn_a  [NUM_CH];
  logic [CNT_W-1:0] last_a [NUM_CH];
  logic [CNT_W-1:0] min_a  [NUM_CH];
  logic [CNT_W-1:0] max_a  [NUM_CH];
  logic [CNT_W-1:0] stl_a  [NUM_CH];
  logic [1:0]       err_a  [NUM_CH];
  logic [NUM_CH-1:0] idle_v;
  logic sel_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ap_perf_channel #(
      .CNT_W        (CNT_W),
      .TS_W         (TS_W),
      .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .finish    (finish),
      .start     (ap_start[g]),
      .ready     (ap_ready[g]),
      .done      (ap_done[g]),
      .cont      (ap_continue[g]),
      .now       (cycle_count),
      .txn_count (txn_a[g]),
      .last_lat  (last_a[g]),
      .min_lat   (min_a[g]),
      .max_lat   (max_a[g]),
      .stall     (stl_a[g]),
      .err       (err_a[g]),
      .idle      (idle_v[g])
    );
  end

  assign all_idle = &idle_v;
  assign sel_ok   = int'(rd_sel) < NUM_CH;

  // Free-running timestamp, frozen by finish.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cycle_count <= '0;
    else if (clear)
      cycle_count <= '0;
    else if (!finish)
      cycle_count <= cycle_count + 1'b1;
  end

  // Registered read mux; illegal selects read as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid     <= 1'b0;
      rd_txn_count <= '0;
      rd_last_lat  <= '0;
      rd_min_lat   <= '0;
      rd_max_lat   <= '0;
      rd_stall     <= '0;
      rd_err       <= '0;
    end else if (clear || !sel_ok) begin
      rd_valid     <= 1'b0;
      rd_txn_count <= '0;
      rd_last_lat  <= '0;
      rd_min_lat   <= '0;
      rd_max_lat   <= '0;
      rd_stall     <= '0;
      rd_err       <= '0;
    end else begin
      rd_valid     <= 1'b1;
      rd_txn_count <= txn_a[rd_sel];
      rd_last_lat  <= last_a[rd_sel];
      rd_min_lat   <= min_a[rd_sel];
      rd_max_lat   <= max_a[rd_sel];
      rd_stall     <= stl_a[rd_sel];
      rd_err       <= err_a[rd_sel];
    end
  end
endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Bench for ap_ctrl_perf_monitor: directed plan, table, random.
// Reference model uses per-channel timestamp queues.
module tb_ap_ctrl_perf_monitor;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 8;
  localparam int TS_W   = 8;
  localparam int MAXI   = 4;
  localparam int SW     = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int TMASK  = (1 << TS_W) - 1;

  logic clock, reset, fin, clr;
  logic [NUM_CH-1:0] st, rdy, dn, ct;
  logic [SW-1:0] rd_sel;
  logic rd_valid, all_idle;
  logic [CNT_W-1:0] rd_txn_count, rd_last_lat;
  logic [CNT_W-1:0] rd_min_lat, rd_max_lat, rd_stall;
  logic [1:0] rd_err;
  logic [TS_W-1:0] cycle_count;

  ap_ctrl_perf_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W),
    .TS_W(TS_W), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clock(clock), .reset(reset),
    .finish(fin), .clear(clr),
    .ap_start(st), .ap_ready(rdy),
    .ap_done(dn), .ap_continue(ct),
    .rd_sel(rd_sel), .rd_valid(rd_valid),
    .rd_txn_count(rd_txn_count),
    .rd_last_lat(rd_last_lat),
    .rd_min_lat(rd_min_lat),
    .rd_max_lat(rd_max_lat),
    .rd_stall(rd_stall), .rd_err(rd_err),
    .cycle_count(cycle_count),
    .all_idle(all_idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  int m_q [NUM_CH][$];
  int m_txn [NUM_CH];
  int m_last [NUM_CH];
  int m_min [NUM_CH];
  int m_max [NUM_CH];
  int m_stall [NUM_CH];
  int m_err [NUM_CH];
  int m_cc;
  int e_valid, e_txn, e_last, e_min, e_max;
  int e_stall, e_err;

  typedef struct {
    int gap; int stl;
    int x_last; int x_min; int x_max;
    int x_stall; int x_txn;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
  endtask

  function automatic void m_clear();
    m_cc = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_q[c].delete();
      m_txn[c] = 0; m_last[c] = 0;
      m_min[c] = CMAX; m_max[c] = 0;
      m_stall[c] = 0; m_err[c] = 0;
    end
  endfunction

  function automatic void rec(int c, int lat);
    m_last[c] = lat;
    if (lat < m_min[c]) m_min[c] = lat;
    if (lat > m_max[c]) m_max[c] = lat;
  endfunction

  function automatic void model_step();
    bit sa, da;
    int lat;
    if (clr) begin
      m_clear();
      return;
    end
    if (fin) return;
    for (int c = 0; c < NUM_CH; c++) begin
      sa = st[c] && rdy[c];
      da = dn[c] && ct[c];
      if (dn[c] && !ct[c] && m_stall[c] < CMAX)
        m_stall[c]++;
      if (sa && m_txn[c] < CMAX) m_txn[c]++;
      if (sa && da) begin
        if (m_q[c].size() == 0) rec(c, 0);
        else begin
          lat = (m_cc - m_q[c].pop_front()) & CMAX;
          rec(c, lat);
          m_q[c].push_back(m_cc);
        end
      end else if (sa) begin
        if (m_q[c].size() == MAXI) m_err[c] |= 1;
        else m_q[c].push_back(m_cc);
      end else if (da) begin
        if (m_q[c].size() == 0) m_err[c] |= 2;
        else begin
          lat = (m_cc - m_q[c].pop_front()) & CMAX;
          rec(c, lat);
        end
      end
    end
    m_cc = (m_cc + 1) & TMASK;
  endfunction

  function automatic int m_idle();
    for (int c = 0; c < NUM_CH; c++)
      if (m_q[c].size() != 0) return 0;
    return 1;
  endfunction

  task automatic tick();
    int s;
    s = int'(rd_sel);
    if (clr || s >= NUM_CH) begin
      e_valid = 0; e_txn = 0; e_last = 0;
      e_min = 0; e_max = 0; e_stall = 0; e_err = 0;
    end else begin
      e_valid = 1; e_txn = m_txn[s];
      e_last = m_last[s]; e_min = m_min[s];
      e_max = m_max[s]; e_stall = m_stall[s];
      e_err = m_err[s];
    end
    model_step();
    @(posedge clock); #1;
    chk("rd_valid", rd_valid, e_valid);
    chk("rd_txn", rd_txn_count, e_txn);
    chk("rd_last", rd_last_lat, e_last);
    chk("rd_min", rd_min_lat, e_min);
    chk("rd_max", rd_max_lat, e_max);
    chk("rd_stall", rd_stall, e_stall);
    chk("rd_err", rd_err, e_err);
    chk("cycle_count", cycle_count, m_cc);
    chk("all_idle", all_idle, m_idle());
  endtask

  task automatic idle_in();
    st = '0; dn = '0; rdy = '1; ct = '1;
    fin = 1'b0; clr = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic read(int ch);
    st = '0; dn = '0;
    rd_sel = SW'(ch);
    tick();
  endtask

  task automatic wait_cc(int t);
    for (int i = 0; i < 300; i++) begin
      if (int'(cycle_count) == t) break;
      tick();
    end
    chk("wait_cc", cycle_count, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{7, 0, 7, 7, 7, 0, 1};
    tbl[1] = '{3, 0, 3, 3, 7, 0, 2};
    tbl[2] = '{2, 4, 6, 3, 7, 4, 3};
    tbl[3] = '{1, 0, 1, 1, 7, 4, 4};
    tbl[4] = '{12, 0, 12, 1, 12, 4, 5};
    m_clear();
    idle_in();
    rd_sel = '0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", rd_valid, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_idle", all_idle, 1);
    chk("rst_min", rd_min_lat, 0);
    reset = 1'b1;
    tick();
    chk("first_valid", rd_valid, 1);
    chk("first_min", rd_min_lat, CMAX);

    // single transaction on ch0
    do_clear();
    wait_cc(10);
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    wait_cc(17);
    dn[0] = 1'b1; tick(); dn[0] = 1'b0;
    read(0);
    chk("a_txn", rd_txn_count, 1);
    chk("a_last", rd_last_lat, 7);
    chk("a_min", rd_min_lat, 7);
    chk("a_max", rd_max_lat, 7);
    chk("a_stall", rd_stall, 0);

    // pipelined ch1
    do_clear();
    for (int i = 0; i < 14; i++) begin
      st[1] = (i == 0 || i == 2 || i == 4);
      dn[1] = (i == 9 || i == 11 || i == 13);
      tick();
    end
    chk("b_idle", all_idle, 1);
    read(1);
    chk("b_txn", rd_txn_count, 3);
    chk("b_last", rd_last_lat, 9);
    chk("b_min", rd_min_lat, 9);
    chk("b_max", rd_max_lat, 9);

    // overflow then underflow on ch2
    do_clear();
    st[2] = 1'b1;
    repeat (5) tick();
    read(2);
    chk("c_err1", rd_err, 1);
    chk("c_txn", rd_txn_count, 5);
    dn[2] = 1'b1;
    repeat (5) tick();
    read(2);
    chk("c_err2", rd_err, 3);
    chk("c_last", rd_last_lat, 6);
    chk("c_min", rd_min_lat, 6);
    chk("c_max", rd_max_lat, 6);

    // backpressure on ch3
    do_clear();
    st[3] = 1'b1; tick(); st[3] = 1'b0;
    tick();
    dn[3] = 1'b1; ct[3] = 1'b0;
    repeat (6) tick();
    ct[3] = 1'b1; tick();
    read(3);
    chk("d_stall", rd_stall, 6);
    chk("d_last", rd_last_lat, 8);

    // timestamp wrap
    do_clear();
    wait_cc(250);
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    wait_cc(4);
    dn[0] = 1'b1; tick();
    read(0);
    chk("e_wrap", rd_last_lat, 10);

    // same-cycle start and done
    do_clear();
    st[0] = 1'b1; dn[0] = 1'b1; tick();
    chk("f_idle0", all_idle, 1);
    dn[0] = 1'b0; tick();
    st[0] = 1'b0; tick(); tick();
    st[0] = 1'b1; dn[0] = 1'b1; tick();
    chk("f_idle1", all_idle, 0);
    st[0] = 1'b0; dn[0] = 1'b0; tick();
    dn[0] = 1'b1; tick();
    chk("f_idle2", all_idle, 1);
    read(0);
    chk("f_txn", rd_txn_count, 3);
    chk("f_last", rd_last_lat, 2);
    chk("f_min", rd_min_lat, 0);
    chk("f_max", rd_max_lat, 3);

    // finish freeze, clear, illegal select
    do_clear();
    begin
      int fcc;
      st[1] = 1'b1; tick(); st[1] = 1'b0;
      fin = 1'b1;
      fcc = int'(cycle_count);
      for (int i = 0; i < 5; i++) begin
        dn[1] = (i == 2);
        tick();
        chk("g_frozen", cycle_count, fcc);
      end
    end
    fin = 1'b0; dn = '0;
    read(1);
    chk("g_txn", rd_txn_count, 1);
    chk("g_last", rd_last_lat, 0);
    chk("g_busy", all_idle, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("g_clr_valid", rd_valid, 0);
    read(1);
    chk("g_clr_txn", rd_txn_count, 0);
    chk("g_clr_min", rd_min_lat, CMAX);
    chk("g_clr_idle", all_idle, 1);
    read(NUM_CH);
    chk("g_bad_valid", rd_valid, 0);
    chk("g_bad_txn", rd_txn_count, 0);

    // stall saturation
    do_clear();
    dn[2] = 1'b1; ct[2] = 1'b0;
    repeat (300) tick();
    ct[2] = 1'b1;
    read(2);
    chk("h_sat", rd_stall, CMAX);

    // table of single transactions on ch4
    idle_in();
    do_clear();
    for (int r = 0; r < 5; r++) begin
      st[4] = 1'b1; tick(); st[4] = 1'b0;
      repeat (tbl[r].gap - 1) tick();
      dn[4] = 1'b1; ct[4] = 1'b0;
      repeat (tbl[r].stl) tick();
      ct[4] = 1'b1; tick();
      dn[4] = 1'b0;
      read(4);
      chk("t_last", rd_last_lat, tbl[r].x_last);
      chk("t_min", rd_min_lat, tbl[r].x_min);
      chk("t_max", rd_max_lat, tbl[r].x_max);
      chk("t_stall", rd_stall, tbl[r].x_stall);
      chk("t_txn", rd_txn_count, tbl[r].x_txn);
      chk("t_err", rd_err, 0);
    end

    // randomized traffic against the model
    do_clear();
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st[c]  = ($urandom % 4) == 0;
        rdy[c] = ($urandom % 4) != 0;
        dn[c]  = ($urandom % 4) == 0;
        ct[c]  = ($urandom % 3) != 0;
      end
      fin = ($urandom % 20) == 0;
      clr = ($urandom % 150) == 0;
      rd_sel = SW'($urandom % 8);
      tick();
    end
    idle_in();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
